// File: rtl/mem_arbiter_if.sv
// Bus bundle between the requestor ports, the RAM and mem_arbiter.
// The arbiter takes the slave modport; the requestor/RAM side takes master.
interface mem_arbiter_if #(
    parameter int unsigned NPORT = 3
);
    logic                 rdy;
    logic                 io_buffer_full;
    logic [NPORT-1:0]     req_valid;
    logic [NPORT-1:0]     req_we;
    logic [NPORT-1:0]     req_signed;
    logic [3*NPORT-1:0]   req_len;
    logic [32*NPORT-1:0]  req_addr;
    logic [32*NPORT-1:0]  req_wdata;
    logic [NPORT-1:0]     flush;
    logic [7:0]           ram_data_i;
    logic [7:0]           ram_data_o;
    logic [31:0]          ram_addr;
    logic                 ram_rw_sel;
    logic [NPORT-1:0]     busy;
    logic [NPORT-1:0]     resp_valid;
    logic [31:0]          resp_data;

    modport slave (
        input  rdy, io_buffer_full, req_valid, req_we, req_signed, req_len, req_addr,
               req_wdata, flush, ram_data_i,
        output ram_data_o, ram_addr, ram_rw_sel, busy, resp_valid, resp_data
    );

    modport master (
        output rdy, io_buffer_full, req_valid, req_we, req_signed, req_len, req_addr,
               req_wdata, flush, ram_data_i,
        input  ram_data_o, ram_addr, ram_rw_sel, busy, resp_valid, resp_data
    );
endinterface

// File: rtl/mem_arbiter.sv
// Multi-port byte-serial RAM arbiter: grants one requestor at a time and moves
// 1..4 bytes per transaction through an 8-bit RAM port (IDLE -> BUSY -> DONE).
module mem_arbiter #(
    parameter int unsigned NPORT    = 3,
    parameter int unsigned ARB_MODE = 0,
    parameter int unsigned IO_STALL = 1
) (
    input logic           clk,
    input logic           rst,
    mem_arbiter_if.slave  bus
);

    localparam int unsigned IdxW = (NPORT > 1) ? $clog2(NPORT) : 1;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e            state_q;
    logic [IdxW-1:0]   gnt_q;
    logic [IdxW-1:0]   last_q;
    logic              we_q;
    logic              signed_q;
    logic [2:0]        len_q;
    logic [2:0]        cnt_q;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic [NPORT-1:0]  busy_q;
    logic [NPORT-1:0]  resp_valid_q;
    logic [31:0]       resp_data_q;

    // ---------------------------------------------------------------- arbitration
    logic              gnt_found;
    logic [IdxW-1:0]   gnt_idx;
    logic [IdxW-1:0]   cand;

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        if (ARB_MODE == 0) begin
            // Scan high to low so the lowest valid index is the last to win.
            for (int i = int'(NPORT) - 1; i >= 0; i--) begin
                cand = IdxW'(i);
                if (bus.req_valid[cand]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = cand;
                end
            end
        end else begin
            // Scan from farthest to nearest after last_q; nearest valid wins.
            for (int i = int'(NPORT); i >= 1; i--) begin
                cand = IdxW'((int'(last_q) + i) % int'(NPORT));
                if (bus.req_valid[cand]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = cand;
                end
            end
        end
    end

    logic [3*NPORT-1:0]  len_sh;
    logic [32*NPORT-1:0] addr_sh;
    logic [32*NPORT-1:0] wdata_sh;
    logic [2:0]          len_raw;
    logic [2:0]          len_eff;
    logic [NPORT-1:0]    gnt_onehot;
    logic [NPORT-1:0]    cur_onehot;

    always_comb begin
        len_sh     = bus.req_len >> (3 * gnt_idx);
        addr_sh    = bus.req_addr >> (32 * gnt_idx);
        wdata_sh   = bus.req_wdata >> (32 * gnt_idx);
        len_raw    = len_sh[2:0];
        len_eff    = (len_raw == 3'd0 || len_raw > 3'd4) ? 3'd4 : len_raw;
        gnt_onehot = NPORT'(1) << gnt_idx;
        cur_onehot = NPORT'(1) << gnt_q;
    end

    // ---------------------------------------------------------------- read assembly
    logic [31:0] rd_bytes;
    logic [31:0] rd_result;
    logic        sign_bit;

    always_comb begin
        rd_bytes = rdata_q;
        for (int i = 0; i < 4; i++) begin
            if (cnt_q != 3'd0 && int'(cnt_q) - 1 == i) rd_bytes[8*i +: 8] = bus.ram_data_i;
        end
        sign_bit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (int'(len_q) - 1 == i) sign_bit = rd_bytes[8*i+7];
        end
        rd_result = rd_bytes;
        for (int i = 0; i < 4; i++) begin
            if (i >= int'(len_q)) rd_result[8*i +: 8] = {8{signed_q & sign_bit}};
        end
    end

    // ---------------------------------------------------------------- RAM port
    logic        io_stalled;
    logic        wr_active;
    logic        flush_g;
    logic [31:0] wdata_cur;

    always_comb begin
        io_stalled = (IO_STALL != 0) && we_q && (addr_q[17:16] == 2'b11) && bus.io_buffer_full;
        wr_active  = (state_q == StBusy) && we_q && !io_stalled && bus.rdy;
        flush_g    = bus.flush[gnt_q];
        wdata_cur  = wdata_q >> {cnt_q, 3'b000};
    end

    assign bus.ram_addr   = (state_q == StBusy) ? addr_q + 32'(cnt_q) : 32'd0;
    assign bus.ram_rw_sel = wr_active;
    assign bus.ram_data_o = wr_active ? wdata_cur[7:0] : 8'd0;
    assign bus.busy       = busy_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;

    // ---------------------------------------------------------------- state machine
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            gnt_q        <= '0;
            last_q       <= IdxW'(NPORT - 1);
            we_q         <= 1'b0;
            signed_q     <= 1'b0;
            len_q        <= 3'd4;
            cnt_q        <= 3'd0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            busy_q       <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
        end else if (bus.rdy) begin
            unique case (state_q)
                StIdle: begin
                    if (gnt_found) begin
                        state_q  <= StBusy;
                        gnt_q    <= gnt_idx;
                        last_q   <= gnt_idx;
                        we_q     <= bus.req_we[gnt_idx];
                        signed_q <= bus.req_signed[gnt_idx];
                        len_q    <= len_eff;
                        addr_q   <= addr_sh[31:0];
                        wdata_q  <= wdata_sh[31:0];
                        cnt_q    <= 3'd0;
                        rdata_q  <= '0;
                        busy_q   <= gnt_onehot;
                    end
                end
                StBusy: begin
                    if (we_q) begin
                        if (!io_stalled) begin
                            if (cnt_q == len_q - 3'd1) begin
                                state_q      <= StDone;
                                busy_q       <= '0;
                                resp_valid_q <= cur_onehot;
                                resp_data_q  <= '0;
                            end else begin
                                cnt_q <= cnt_q + 3'd1;
                            end
                        end
                    end else if (flush_g) begin
                        // Abort wins even on the last capture cycle.
                        state_q <= StIdle;
                        busy_q  <= '0;
                    end else begin
                        rdata_q <= rd_bytes;
                        if (cnt_q == len_q) begin
                            state_q      <= StDone;
                            busy_q       <= '0;
                            resp_valid_q <= cur_onehot;
                            resp_data_q  <= rd_result;
                        end else begin
                            cnt_q <= cnt_q + 3'd1;
                        end
                    end
                end
                StDone: begin
                    state_q      <= StIdle;
                    resp_valid_q <= '0;
                    resp_data_q  <= '0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a fixed-priority DUT carries the main checks,
// a round-robin twin sharing the same inputs is used for grant-order checks.
module tb_mem_arbiter;

    localparam int unsigned NP = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if #(.NPORT(NP)) bus ();
    mem_arbiter_if #(.NPORT(NP)) bus_rr ();

    mem_arbiter #(.NPORT(NP), .ARB_MODE(0), .IO_STALL(1)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mem_arbiter #(.NPORT(NP), .ARB_MODE(1), .IO_STALL(1)) u_dut_rr (
        .clk (clk),
        .rst (rst),
        .bus (bus_rr)
    );

    assign bus_rr.rdy            = bus.rdy;
    assign bus_rr.io_buffer_full = bus.io_buffer_full;
    assign bus_rr.req_valid      = bus.req_valid;
    assign bus_rr.req_we         = bus.req_we;
    assign bus_rr.req_signed     = bus.req_signed;
    assign bus_rr.req_len        = bus.req_len;
    assign bus_rr.req_addr       = bus.req_addr;
    assign bus_rr.req_wdata      = bus.req_wdata;
    assign bus_rr.flush          = bus.flush;
    assign bus_rr.ram_data_i     = bus.ram_data_i;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // RAM model: the byte for the address seen in one cycle appears the next.
    logic [7:0]  mem [logic [31:0]];
    logic [31:0] prev_addr = '0;
    initial begin
        bus.ram_data_i = 8'h00;
        forever begin
            @(negedge clk);
            bus.ram_data_i = mem.exists(prev_addr) ? mem[prev_addr] : 8'h00;
            prev_addr      = bus.ram_addr;
        end
    end

    logic [31:0] addr_log[$];
    logic [7:0]  wdat_log[$];
    int          first_wr;
    int          bad_o = 0;
    logic [2:0]  first_busy;

    task automatic set_req(input int p, input logic we, input logic sgn, input logic [2:0] len,
                           input logic [31:0] addr, input logic [31:0] wdata);
        bus.req_we[p]            = we;
        bus.req_signed[p]        = sgn;
        bus.req_len[3*p +: 3]    = len;
        bus.req_addr[32*p +: 32] = addr;
        bus.req_wdata[32*p +: 32] = wdata;
        bus.req_valid[p]         = 1'b1;
    endtask

    // Issues one request at a negedge and runs it to its resp_valid pulse.
    // edges counts rising edges from the accepting edge (inclusive) to the pulse.
    task automatic run_txn(input string tag, input int p, input logic we, input logic sgn,
                           input logic [2:0] len, input logic [31:0] addr,
                           input logic [31:0] wdata, input int stall_n,
                           output int edges, output logic [31:0] data);
        int busy_n;
        bit done;
        set_req(p, we, sgn, len, addr, wdata);
        bus.io_buffer_full = (stall_n > 0);
        addr_log.delete();
        wdat_log.delete();
        first_wr   = 0;
        first_busy = '0;
        busy_n     = 0;
        edges      = 0;
        done       = 1'b0;
        data       = '1;
        for (int t = 0; t < 40 && !done; t++) begin
            @(negedge clk);
            edges++;
            if (bus.busy != '0) begin
                busy_n++;
                if (busy_n == 1) first_busy = bus.busy;
                addr_log.push_back(bus.ram_addr);
            end
            if (bus.ram_rw_sel) begin
                wdat_log.push_back(bus.ram_data_o);
                if (first_wr == 0) first_wr = busy_n;
            end else if (bus.ram_data_o != 8'h00) begin
                bad_o++;
            end
            if (bus.resp_valid[p]) begin
                done             = 1'b1;
                data             = bus.resp_data;
                bus.req_valid[p] = 1'b0;
            end
            if (stall_n > 0 && busy_n == stall_n && bus.io_buffer_full) begin
                @(posedge clk);
                #1 bus.io_buffer_full = 1'b0;
            end
        end
        bus.io_buffer_full = 1'b0;
        check({tag, "_done"}, 32'(done), 32'd1);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    int          e;
    logic [31:0] d;
    logic [2:0]  g_fp [4];
    logic [2:0]  g_rr [4];
    int          n_fp, n_rr;
    logic [2:0]  prev_fp, prev_rr;
    int          frozen_bad;
    int          busy_n;

    initial begin
        rst                = 1'b0;
        bus.rdy            = 1'b1;
        bus.io_buffer_full = 1'b0;
        bus.req_valid      = '0;
        bus.req_we         = '0;
        bus.req_signed     = '0;
        bus.req_len        = '0;
        bus.req_addr       = '0;
        bus.req_wdata      = '0;
        bus.flush          = '0;
        mem[32'h100] = 8'h11; mem[32'h101] = 8'h22; mem[32'h102] = 8'h33; mem[32'h103] = 8'h44;
        mem[32'h10]  = 8'h80; mem[32'h20]  = 8'h01; mem[32'h21]  = 8'h80;

        // Reset state.
        @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
        check("rst_resp_data", bus.resp_data, 32'h0);
        check("rst_ram_addr", bus.ram_addr, 32'h0);
        check("rst_rw_sel", 32'(bus.ram_rw_sel), 32'h0);
        rst = 1'b1;

        // Grant order with all ports continuously valid.
        @(negedge clk);
        for (int p = 0; p < 3; p++) set_req(p, 1'b0, 1'b0, 3'd1, 32'h10, 32'h0);
        n_fp = 0; n_rr = 0; prev_fp = '0; prev_rr = '0;
        for (int i = 0; i < 4; i++) begin g_fp[i] = '0; g_rr[i] = '0; end
        for (int t = 0; t < 60 && (n_fp < 4 || n_rr < 4); t++) begin
            @(negedge clk);
            if (prev_fp == '0 && bus.busy != '0 && n_fp < 4) begin g_fp[n_fp] = bus.busy; n_fp++; end
            if (prev_rr == '0 && bus_rr.busy != '0 && n_rr < 4) begin
                g_rr[n_rr] = bus_rr.busy;
                n_rr++;
            end
            prev_fp = bus.busy;
            prev_rr = bus_rr.busy;
        end
        check("fp_grant0", 32'(g_fp[0]), 32'h1);
        check("fp_grant1", 32'(g_fp[1]), 32'h1);
        check("fp_grant2", 32'(g_fp[2]), 32'h1);
        check("rr_grant0", 32'(g_rr[0]), 32'h1);
        check("rr_grant1", 32'(g_rr[1]), 32'h2);
        check("rr_grant2", 32'(g_rr[2]), 32'h4);
        check("rr_grant3", 32'(g_rr[3]), 32'h1);
        bus.req_valid = '0;
        repeat (4) @(negedge clk);
        pulse_reset();

        // Port 1 reads 4 bytes at 0x100.
        run_txn("rd4", 1, 1'b0, 1'b0, 3'd4, 32'h100, 32'h0, 0, e, d);
        check("rd4_edges", 32'(e), 32'd6);
        check("rd4_data", d, 32'h44332211);
        check("rd4_busy_onehot", 32'(first_busy), 32'h2);
        check("rd4_addr0", addr_log[0], 32'h100);
        check("rd4_addr3", addr_log[3], 32'h103);
        @(negedge clk);
        check("rd4_resp_clear", bus.resp_data, 32'h0);

        // Sign / zero extension.
        run_txn("rd1s", 0, 1'b0, 1'b1, 3'd1, 32'h10, 32'h0, 0, e, d);
        check("rd1s_edges", 32'(e), 32'd3);
        check("rd1s_data", d, 32'hFFFFFF80);
        @(negedge clk);
        run_txn("rd2u", 0, 1'b0, 1'b0, 3'd2, 32'h20, 32'h0, 0, e, d);
        check("rd2u_data", d, 32'h00008001);
        @(negedge clk);
        run_txn("rd2s", 0, 1'b0, 1'b1, 3'd2, 32'h20, 32'h0, 0, e, d);
        check("rd2s_data", d, 32'hFFFF8001);
        @(negedge clk);
        run_txn("rd3s", 2, 1'b0, 1'b1, 3'd3, 32'h100, 32'h0, 0, e, d);
        check("rd3s_data", d, 32'h00332211);
        @(negedge clk);
        run_txn("rd0", 1, 1'b0, 1'b0, 3'd0, 32'h100, 32'h0, 0, e, d);
        check("rd_len0_edges", 32'(e), 32'd6);
        check("rd_len0_data", d, 32'h44332211);
        @(negedge clk);

        // Plain write; io_buffer_full must not stall a non-I/O address.
        run_txn("wr2", 0, 1'b1, 1'b0, 3'd2, 32'h200, 32'hAABBCCDD, 3, e, d);
        check("wr2_edges", 32'(e), 32'd3);
        check("wr2_resp", d, 32'h0);
        check("wr2_nbytes", 32'(wdat_log.size()), 32'd2);
        check("wr2_byte0", 32'(wdat_log[0]), 32'hDD);
        check("wr2_byte1", 32'(wdat_log[1]), 32'hCC);
        check("wr2_addr1", addr_log[1], 32'h201);
        @(negedge clk);

        // I/O-space write stalled for 3 cycles.
        run_txn("wrio", 2, 1'b1, 1'b0, 3'd1, 32'h30000, 32'h41, 3, e, d);
        check("wrio_edges", 32'(e), 32'd5);
        check("wrio_first_strobe", 32'(first_wr), 32'd4);
        check("wrio_byte", 32'(wdat_log[0]), 32'h41);
        @(negedge clk);

        // Flush in the third BUSY cycle with port 1 pending.
        set_req(0, 1'b0, 1'b0, 3'd4, 32'h100, 32'h0);
        set_req(1, 1'b0, 1'b0, 3'd1, 32'h10, 32'h0);
        busy_n = 0;
        for (int t = 0; t < 20 && busy_n < 3; t++) begin
            @(negedge clk);
            if (bus.busy == 3'b001) busy_n++;
        end
        check("fl_reach", 32'(busy_n), 32'd3);
        check("fl_addr", bus.ram_addr, 32'h102);
        bus.flush[0]     = 1'b1;
        bus.req_valid[0] = 1'b0;
        @(negedge clk);
        check("fl_idle_busy", 32'(bus.busy), 32'h0);
        check("fl_no_resp", 32'(bus.resp_valid), 32'h0);
        bus.flush[0] = 1'b0;
        @(negedge clk);
        check("fl_next_grant", 32'(bus.busy), 32'h2);
        busy_n = 0;
        for (int t = 0; t < 10 && busy_n == 0; t++) begin
            @(negedge clk);
            if (bus.resp_valid != '0) begin
                busy_n = 1;
                check("fl_p1_resp", 32'(bus.resp_valid), 32'h2);
                check("fl_p1_data", bus.resp_data, 32'h80);
            end
        end
        check("fl_p1_done", 32'(busy_n), 32'd1);
        bus.req_valid[1] = 1'b0;
        @(negedge clk);

        // Flush on the final capture cycle aborts the read.
        set_req(0, 1'b0, 1'b0, 3'd1, 32'h10, 32'h0);
        @(negedge clk);
        @(negedge clk);
        bus.flush[0] = 1'b1;
        @(negedge clk);
        check("flfin_no_resp", 32'(bus.resp_valid), 32'h0);
        check("flfin_busy", 32'(bus.busy), 32'h0);
        bus.flush[0]     = 1'b0;
        bus.req_valid[0] = 1'b0;
        @(negedge clk);
        check("flfin_no_resp2", 32'(bus.resp_valid), 32'h0);

        // rdy low mid-write freezes the transfer and drops the strobe.
        set_req(0, 1'b1, 1'b0, 3'd2, 32'h200, 32'h0000BEEF);
        @(negedge clk);
        bus.rdy = 1'b0;
        #1;
        check("frz_rw_sel", 32'(bus.ram_rw_sel), 32'h0);
        check("frz_data_o", 32'(bus.ram_data_o), 32'h0);
        @(negedge clk);
        @(negedge clk);
        check("frz_busy", 32'(bus.busy), 32'h1);
        check("frz_addr", bus.ram_addr, 32'h200);
        bus.rdy = 1'b1;
        #1;
        check("frz_resume_byte", 32'(bus.ram_data_o), 32'hEF);
        @(negedge clk);
        check("frz_addr1", bus.ram_addr, 32'h201);
        check("frz_byte1", 32'(bus.ram_data_o), 32'hBE);
        @(negedge clk);
        check("frz_resp", 32'(bus.resp_valid), 32'h1);
        bus.req_valid[0] = 1'b0;
        @(negedge clk);

        // Reset mid-write, then rdy held low for 5 cycles.
        set_req(0, 1'b1, 1'b0, 3'd4, 32'h200, 32'h01020304);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstw_busy", 32'(bus.busy), 32'h0);
        check("rstw_rw_sel", 32'(bus.ram_rw_sel), 32'h0);
        check("rstw_addr", bus.ram_addr, 32'h0);
        check("rstw_data_o", 32'(bus.ram_data_o), 32'h0);
        bus.rdy = 1'b0;
        set_req(1, 1'b0, 1'b0, 3'd1, 32'h10, 32'h0);
        set_req(2, 1'b0, 1'b0, 3'd1, 32'h10, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        frozen_bad = 0;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            if (bus.busy != '0 || bus.ram_rw_sel || bus.ram_addr != '0) frozen_bad++;
            if (bus_rr.busy != '0 || bus_rr.ram_rw_sel) frozen_bad++;
        end
        check("rdy_frozen", 32'(frozen_bad), 32'd0);
        bus.rdy = 1'b1;
        @(negedge clk);
        check("rel_grant_fp", 32'(bus.busy), 32'h1);
        check("rel_grant_rr", 32'(bus_rr.busy), 32'h1);
        bus.req_valid = '0;

        check("data_o_idle_zero", 32'(bad_o), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
